// File: rtl/seg7_hex_scan.sv
// Eight-digit time-multiplexed hex driver for a common-anode 7-segment display.
// Each digit stays lit for SCAN_DIV clocks. The word is latched once per frame, so a frame never tears.
module seg7_hex_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             digit_done;
  logic             frame_done;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  assign digit_done = (cnt_q == CNT_MAX);
  assign frame_done = digit_done && (idx_q == 3'd7);

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave it unassigned and infer a latch.
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (digit_done) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    if (frame_done) begin
      shadow_d = data;
    end
    // Outputs reflect the current (pre-edge) digit, so they lag idx by one clock.
    an_d  = ~(8'b0000_0001 << idx_q);
    seg_d = hex_to_seg(shadow_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!clr) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= data;
      seg_q    <= 8'hFF;
      an_q     <= 8'hFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Self-checking bench for seg7_hex_scan: SCAN_DIV=4 and SCAN_DIV=1 instances share stimulus.
// A cycle-count reference model feeds a scoreboard; constant tables cover the documented cases.
module tb_seg7_hex_scan;

  logic        clk;
  logic        clr;
  logic [31:0] data;
  logic [7:0]  seg4, an4, seg1, an1;

  int checks   = 0;
  int failures = 0;

  seg7_hex_scan #(.SCAN_DIV(4)) u_dut4 (
    .clk (clk),
    .clr (clr),
    .data(data),
    .SEG (seg4),
    .AN  (an4)
  );

  seg7_hex_scan #(.SCAN_DIV(1)) u_dut1 (
    .clk (clk),
    .clr (clr),
    .data(data),
    .SEG (seg1),
    .AN  (an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Model state: edges since reset release and the word owning the current frame.
  typedef struct {
    int          t;
    logic [31:0] word;
  } mdl_t;

  typedef struct {
    logic [7:0] seg4;
    logic [7:0] an4;
    logic [7:0] seg1;
    logic [7:0] an1;
    logic       live;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  seg [8];
  } vec_t;

  mdl_t m4, m1;
  exp_t sb[$];
  vec_t vecs[4];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t model_step(input mdl_t m, input int div, input logic c,
                                      input logic [31:0] d, output logic [7:0] seg,
                                      output logic [7:0] an);
    mdl_t       n;
    int         dig;
    logic [3:0] nib;
    n = m;
    if (!c) begin
      n.t    = 0;
      n.word = d;
      seg    = 8'hFF;
      an     = 8'hFF;
    end else begin
      dig = (m.t / div) % 8;
      nib = 4'(m.word >> (4 * dig));
      seg = SEG_LUT[nib];
      an  = ~(8'b0000_0001 << dig);
      if ((m.t % (8 * div)) == (8 * div - 1)) n.word = d;
      n.t = m.t + 1;
    end
    return n;
  endfunction

  // One clock: predict from the inputs about to be sampled, then compare just after the edge.
  task automatic tick();
    exp_t e;
    exp_t g;
    m4 = model_step(m4, 4, clr, data, e.seg4, e.an4);
    m1 = model_step(m1, 1, clr, data, e.seg1, e.an1);
    e.live = clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("sb_seg4", seg4, g.seg4);
    check("sb_an4", an4, g.an4);
    check("sb_seg1", seg1, g.seg1);
    check("sb_an1", an1, g.an1);
    if (g.live) check("an1_one_low", 8'($countones(~an1)), 8'd1);
  endtask

  task automatic do_reset(input logic [31:0] w, input int n);
    data = w;
    clr  = 1'b0;
    repeat (n) tick();
    check("reset_seg4", seg4, 8'hFF);
    check("reset_an4", an4, 8'hFF);
    check("reset_an1", an1, 8'hFF);
    clr = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int d;
    clr  = 1'b0;
    data = '0;
    m4   = '{t: 0, word: 32'h0};
    m1   = '{t: 0, word: 32'h0};

    vecs[0].data = 32'h12345678;
    vecs[0].seg  = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    vecs[1].data = 32'hFEDCBA98;
    vecs[1].seg  = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[2].data = 32'h01234567;
    vecs[2].seg  = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    vecs[3].data = 32'hC0FFEE00;
    vecs[3].seg  = '{8'hC0, 8'hC0, 8'h86, 8'h86, 8'h8E, 8'h8E, 8'hC0, 8'hC6};

    // Full frames for each table word, then the wrap back to digit 0.
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].data, 3);
      for (int k = 0; k <= 32; k++) begin
        tick();
        d = (k / 4) % 8;
        check("vec_seg", seg4, vecs[v].seg[d]);
        check("vec_an", an4, 8'(~(8'b0000_0001 << d)));
      end
    end

    // Word change while digit 3 is lit must not reach this frame.
    do_reset(32'h11111111, 2);
    for (int k = 0; k < 64; k++) begin
      if (k == 12) data = 32'h22222222;
      tick();
      check("tear_seg", seg4, (k < 32) ? 8'hF9 : 8'hA4);
    end

    // Reset while digit 5 is lit: dark next edge, then digit 0 of the new word.
    do_reset(32'h12345678, 2);
    repeat (22) tick();
    check("pre_mid_an", an4, 8'hDF);
    data = 32'hABCDEF01;
    clr  = 1'b0;
    tick();
    check("mid_rst_seg", seg4, 8'hFF);
    check("mid_rst_an", an4, 8'hFF);
    clr = 1'b1;
    tick();
    check("resume_seg", seg4, 8'hF9);
    check("resume_an", an4, 8'hFE);

    // SCAN_DIV=1 rotates every clock.
    do_reset(32'h89ABCDEF, 2);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("div1_an", an1, 8'(~(8'b0000_0001 << (k % 8))));
    end
    check("div1_seg_last", seg1, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
